// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, select and cmd encodings for the multi-cycle controller
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    function automatic logic is_arith(input logic [3:0] cmd);
        return cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP || cmd == CMD_CMN;
    endfunction
    function automatic logic is_cmp_like(input logic [3:0] cmd);
        return cmd == CMD_CMP || cmd == CMD_CMN || cmd == CMD_TST;
    endfunction
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps data-processing cmd/S bits to ALUControl and FlagW
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic       ALUOp,
    input  logic [4:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW
);
    logic [3:0] cmd;
    logic [1:0] alu;
    // cmd decode; outside execute states the ALU adds and no flags update
    always_comb begin
        cmd = Funct[4:1];
        alu = (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
              (cmd == CMD_AND || cmd == CMD_TST) ? ALU_AND :
              (cmd == CMD_ORR)                   ? ALU_ORR : ALU_ADD;
        ALUControl = ALUOp ? alu : ALU_ADD;
        FlagW = ALUOp ? {Funct[0], Funct[0] & is_arith(cmd)} : 2'b00;
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle main controller; CTRL_CMP_NOWB_EN suppresses ALUWB write for CMP/CMN/TST
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);
    state_t     state_q, state_d, cur;
    logic       alu_op, ir_write, next_pc, regw, memw, branch;
    logic [1:0] dec_ctl, dec_flagw;
    assign cur    = RESET ? S_FETCH : state_q;
    assign alu_op = (cur == S_EXECUTER) || (cur == S_EXECUTEI);
    mc_alu_decoder u_dec (
        .ALUOp      (alu_op),
        .Funct      (Funct[4:0]),
        .ALUControl (dec_ctl),
        .FlagW      (dec_flagw)
    );
    // state register with synchronous reset to FETCH
    always_ff @(posedge CLK) begin
        state_q <= RESET ? S_FETCH : state_d;
    end
    // next-state sequencing
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = (Op == 2'b01) ? S_MEMADR :
                                  (Op == 2'b10) ? S_BRANCH :
                                  (Op == 2'b00) ? (Funct[5] ? S_EXECUTEI : S_EXECUTER) : S_FETCH;
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end
    // per-state datapath selects and raw enables; reset presents FETCH selects
    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        case (cur)
            S_FETCH: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                regw      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            S_EXECUTER: ALUControl = dec_ctl;
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_ctl;
            end
            S_ALUWB: begin
`ifdef CTRL_CMP_NOWB_EN
                regw = ~is_cmp_like(Funct[4:1]);
`else
                regw = 1'b1;
`endif
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end
    assign IRWrite = ir_write & ~RESET;
    assign NextPC  = next_pc & ~RESET;
    assign RegW    = regw & ~RESET;
    assign MemW    = memw & ~RESET;
    assign FlagW   = RESET ? 2'b00 : dec_flagw;
    assign PCS     = ~RESET & (branch | (regw & (Rd == 4'hF)));
    assign ImmSrc  = Op;
    assign RegSrc  = {Op == 2'b01, Op == 2'b10};
endmodule
